// File: rtl/pll_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pll_pkg                                                    |
// | Description : Shared types and default constants for the PLL supervisor. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pll_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_sup_state_t;

  localparam int PLL_RST_CYCLES    = 16;
  localparam int PLL_LOCK_TIMEOUT  = 50000;
  localparam int PLL_STABLE_CYCLES = 1024;
  localparam int PLL_MAX_RETRIES   = 3;

  // Width of a down-counter that must hold (largest interval - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_2ff                                                   |
// | Description : 1-bit two-flop synchronizer, async active-high reset to 0. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pll_lock_supervisor                                        |
// | Description : PLL reset sequencer, lock qualifier and retry supervisor.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pll_lock_supervisor
  import pll_pkg::*;
#(
  parameter int RST_CYCLES    = PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = PLL_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = PLL_STABLE_CYCLES,
  parameter int MAX_RETRIES   = PLL_MAX_RETRIES
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               locked,
  input  logic                               relock_req,
  output logic                               pll_rst,
  output logic                               sys_rst,
  output logic                               ready,
  output logic                               fail,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int c_rc_w  = $clog2(MAX_RETRIES + 1);
  localparam int c_cnt_w = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [c_cnt_w-1:0] c_rst_load     = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_load = c_cnt_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_stable_load  = c_cnt_w'(STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
  localparam logic [c_rc_w-1:0]  c_rc_max       = c_rc_w'(MAX_RETRIES);
  localparam logic [c_rc_w-1:0]  c_rc_one       = c_rc_w'(1);

  pll_sup_state_t      r_state, w_state_next;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_next;
  logic [c_rc_w-1:0]   r_retry, w_retry_next, w_retry_inc;
  logic                r_lock_lost, w_lock_lost_next;
  logic                r_pll_rst, w_pll_rst_next;
  logic                r_sys_rst, w_sys_rst_next;
  logic                r_ready, w_ready_next;
  logic                r_fail, w_fail_next;
  logic                w_lk;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (w_lk)
  );

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state     <= PLL_RST;
      r_cnt       <= c_rst_load;
      r_retry     <= '0;
      r_lock_lost <= 1'b0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_retry     <= w_retry_next;
      r_lock_lost <= w_lock_lost_next;
      r_pll_rst   <= w_pll_rst_next;
      r_sys_rst   <= w_sys_rst_next;
      r_ready     <= w_ready_next;
      r_fail      <= w_fail_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_retry_next     = r_retry;
    w_lock_lost_next = r_lock_lost;
    w_retry_inc      = (r_retry == c_rc_max) ? r_retry : r_retry + c_rc_one;

    if (relock_req) begin
      w_state_next     = PLL_RST;
      w_cnt_next       = c_rst_load;
      w_retry_next     = '0;
      w_lock_lost_next = 1'b0;
    end else begin
      case (r_state)
        PLL_RST: begin
          if (r_cnt == '0) begin
            w_state_next = WAIT_LOCK;
            w_cnt_next   = c_timeout_load;
          end else begin
            w_cnt_next = r_cnt - c_cnt_one;
          end
        end
        WAIT_LOCK: begin
          // A lock seen on the expiry cycle still counts as a lock.
          if (w_lk) begin
            w_state_next = STABLE;
            w_cnt_next   = c_stable_load;
          end else if (r_cnt == '0) begin
            w_retry_next = w_retry_inc;
            if (w_retry_inc == c_rc_max) begin
              w_state_next = FAIL;
            end else begin
              w_state_next = PLL_RST;
              w_cnt_next   = c_rst_load;
            end
          end else begin
            w_cnt_next = r_cnt - c_cnt_one;
          end
        end
        STABLE: begin
          if (!w_lk) begin
            w_state_next = WAIT_LOCK;
            w_cnt_next   = c_timeout_load;
          end else if (r_cnt == '0) begin
            w_state_next = RUN;
            w_retry_next = '0;
          end else begin
            w_cnt_next = r_cnt - c_cnt_one;
          end
        end
        RUN: begin
          if (!w_lk) begin
            w_state_next     = PLL_RST;
            w_cnt_next       = c_rst_load;
            w_lock_lost_next = 1'b1;
          end
        end
        FAIL: begin
          w_state_next = FAIL;
        end
        default: begin
          w_state_next = PLL_RST;
          w_cnt_next   = c_rst_load;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register with it.
    w_pll_rst_next = (w_state_next == PLL_RST);
    w_sys_rst_next = (w_state_next != RUN);
    w_ready_next   = (w_state_next == RUN);
    w_fail_next    = (w_state_next == FAIL);
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign fail        = r_fail;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pll_lock_supervisor                                     |
// | Description : Self-checking bench for pll_lock_supervisor.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int RC_W          = $clog2(MAX_RETRIES + 1);
  localparam int VEC_W         = 5 + RC_W;
  // {pll_rst, sys_rst, ready, fail, lock_lost, retry_count}
  localparam logic [VEC_W-1:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {RC_W{1'b0}}};
  // Locked-rise to sys_rst-fall: 2 sync edges + 1 entry edge + STABLE_CYCLES.
  localparam int LOCK_TO_RUN = 2 + 1 + STABLE_CYCLES;

  localparam int P_PULSE  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAIL   = 4;

  logic            refclk     = 1'b0;
  logic            rst        = 1'b1;
  logic            locked     = 1'b0;
  logic            relock_req = 1'b0;
  logic            pll_rst, sys_rst, ready, fail, lock_lost;
  logic [RC_W-1:0] retry_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase, edges spent in the phase, retries, sticky loss.
  int   m_phase, m_age, m_retries;
  logic m_lost, m_h0, m_h1;

  always #10 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .locked      (locked),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .fail        (fail),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  function automatic logic [VEC_W-1:0] dut_vec();
    return {pll_rst, sys_rst, ready, fail, lock_lost, retry_count};
  endfunction

  function automatic logic [VEC_W-1:0] model_vec();
    logic run;
    run = (m_phase == P_RUN);
    return {(m_phase == P_PULSE), !run, run, (m_phase == P_FAIL), m_lost, RC_W'(m_retries)};
  endfunction

  task automatic model_reset();
    m_phase = P_PULSE; m_age = 0; m_retries = 0; m_lost = 1'b0; m_h0 = 1'b0; m_h1 = 1'b0;
  endtask

  task automatic model_enter(input int p);
    m_phase = p;
    m_age   = 0;
  endtask

  task automatic model_step();
    logic lk;
    lk = m_h1;                     // locked as seen two edges ago
    m_h1 = m_h0;
    m_h0 = locked;
    m_age++;
    if (relock_req) begin
      model_enter(P_PULSE); m_retries = 0; m_lost = 1'b0;
    end else begin
      case (m_phase)
        P_PULSE:  if (m_age == RST_CYCLES) model_enter(P_WAIT);
        P_WAIT: begin
          if (lk) model_enter(P_STABLE);
          else if (m_age == LOCK_TIMEOUT) begin
            m_retries++;
            model_enter((m_retries >= MAX_RETRIES) ? P_FAIL : P_PULSE);
          end
        end
        P_STABLE: begin
          if (!lk) model_enter(P_WAIT);
          else if (m_age == STABLE_CYCLES) begin model_enter(P_RUN); m_retries = 0; end
        end
        P_RUN:    if (!lk) begin m_lost = 1'b1; model_enter(P_PULSE); end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    if (rst) model_reset(); else model_step();
    @(negedge refclk);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge refclk);
    n_checks++;
    if (dut_vec() !== RESET_VEC) $display("FAIL reset_values dut=%b exp=%b", dut_vec(), RESET_VEC);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_nominal_lock();
    int width = 0;
    int n = 0;
    while (pll_rst === 1'b1 && width < 50) begin
      width++; tick();
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL model t=%0t dut=%b exp=%b", $time, dut_vec(), model_vec());
      else n_pass++;
    end
    n_checks++;
    if (width != RST_CYCLES) $display("FAIL first_pll_rst_width got=%0d exp=%0d", width, RST_CYCLES);
    else n_pass++;
    repeat (10) tick();
    locked = 1'b1;
    while (sys_rst === 1'b1 && n < 100) begin
      n++; tick();
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL model t=%0t dut=%b exp=%b", $time, dut_vec(), model_vec());
      else n_pass++;
    end
    n_checks++;
    if (n != LOCK_TO_RUN) $display("FAIL nominal_release got=%0d exp=%0d", n, LOCK_TO_RUN);
    else n_pass++;
    n_checks++;
    if ({ready, retry_count} !== {1'b1, RC_W'(0)}) $display("FAIL nominal_ready got=%b exp=%b", {ready, retry_count}, {1'b1, RC_W'(0)});
    else n_pass++;
  endtask

  task automatic test_lost_lock();
    int n = 0;
    int width = 0;
    locked = 1'b0;
    while (sys_rst === 1'b0 && n < 20) begin n++; tick(); end
    n_checks++;
    if (n != 3) $display("FAIL lost_lock_latency got=%0d exp=3", n);
    else n_pass++;
    n_checks++;
    if ({pll_rst, lock_lost} !== 2'b11) $display("FAIL lost_lock_outputs got=%b exp=11", {pll_rst, lock_lost});
    else n_pass++;
    while (pll_rst === 1'b1 && width < 50) begin width++; tick(); end
    n_checks++;
    if (width != RST_CYCLES) $display("FAIL lost_lock_pulse got=%0d exp=%0d", width, RST_CYCLES);
    else n_pass++;
    locked = 1'b1;
    n = 0;
    while (sys_rst === 1'b1 && n < 100) begin
      n++; tick();
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL model t=%0t dut=%b exp=%b", $time, dut_vec(), model_vec());
      else n_pass++;
    end
    n_checks++;
    if ({ready, lock_lost} !== 2'b11) $display("FAIL lost_lock_sticky got=%b exp=11", {ready, lock_lost});
    else n_pass++;
  endtask

  task automatic test_lock_bounce();
    int n = 0;
    locked = 1'b0; relock_req = 1'b1; tick(); relock_req = 1'b0;
    n_checks++;
    if ({pll_rst, lock_lost} !== 2'b10) $display("FAIL relock_clears_lost got=%b exp=10", {pll_rst, lock_lost});
    else n_pass++;
    while (pll_rst === 1'b1 && n < 50) begin n++; tick(); end
    locked = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) locked = 1'b0;
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL bounce_model t=%0t dut=%b exp=%b", $time, dut_vec(), model_vec());
      else n_pass++;
    end
    locked = 1'b1;
    n = 0;
    while (sys_rst === 1'b1 && n < 100) begin n++; tick(); end
    n_checks++;
    if (n != LOCK_TO_RUN) $display("FAIL bounce_release got=%0d exp=%0d", n, LOCK_TO_RUN);
    else n_pass++;
  endtask

  task automatic test_retries_to_fail();
    int width;
    int gap;
    locked = 1'b0; relock_req = 1'b1; tick(); relock_req = 1'b0;
    for (int i = 1; i <= MAX_RETRIES; i++) begin
      width = 0;
      while (pll_rst === 1'b1 && width < 50) begin width++; tick(); end
      n_checks++;
      if (width != RST_CYCLES) $display("FAIL retry_pulse%0d got=%0d exp=%0d", i, width, RST_CYCLES);
      else n_pass++;
      gap = 0;
      while (pll_rst === 1'b0 && fail === 1'b0 && gap < 100) begin
        gap++; tick();
        n_checks++;
        if (dut_vec() !== model_vec()) $display("FAIL model t=%0t dut=%b exp=%b", $time, dut_vec(), model_vec());
        else n_pass++;
      end
      n_checks++;
      if (gap != LOCK_TIMEOUT) $display("FAIL retry_wait%0d got=%0d exp=%0d", i, gap, LOCK_TIMEOUT);
      else n_pass++;
      n_checks++;
      if (retry_count !== RC_W'(i)) $display("FAIL retry_count%0d got=%0d exp=%0d", i, retry_count, i);
      else n_pass++;
    end
    repeat (30) begin
      tick();
      n_checks++;
      if ({pll_rst, sys_rst, ready, fail} !== 4'b0101) $display("FAIL fail_hold got=%b exp=0101", {pll_rst, sys_rst, ready, fail});
      else n_pass++;
    end
  endtask

  task automatic test_recovery();
    int width = 0;
    int n = 0;
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    n_checks++;
    if ({fail, lock_lost, retry_count, pll_rst} !== {2'b00, RC_W'(0), 1'b1})
      $display("FAIL recovery_clear got=%b exp=%b", {fail, lock_lost, retry_count, pll_rst}, {2'b00, RC_W'(0), 1'b1});
    else n_pass++;
    while (pll_rst === 1'b1 && width < 50) begin width++; tick(); end
    n_checks++;
    if (width != RST_CYCLES) $display("FAIL recovery_pulse got=%0d exp=%0d", width, RST_CYCLES);
    else n_pass++;
    locked = 1'b1;
    while (sys_rst === 1'b1 && n < 100) begin n++; tick(); end
    n_checks++;
    if (n != LOCK_TO_RUN) $display("FAIL recovery_release got=%0d exp=%0d", n, LOCK_TO_RUN);
    else n_pass++;
  endtask

  task automatic test_timeout_boundary();
    int n = 0;
    locked = 1'b0; relock_req = 1'b1; tick(); relock_req = 1'b0;
    while (pll_rst === 1'b1 && n < 50) begin n++; tick(); end
    // Synced lock arrives on exactly the edge where the wait expires.
    repeat (LOCK_TIMEOUT - 3) tick();
    locked = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({pll_rst, sys_rst, retry_count} !== {2'b01, RC_W'(0)})
      $display("FAIL timeout_boundary got=%b exp=%b", {pll_rst, sys_rst, retry_count}, {2'b01, RC_W'(0)});
    else n_pass++;
    n = 0;
    while (sys_rst === 1'b1 && n < 100) begin n++; tick(); end
    n_checks++;
    if (n != STABLE_CYCLES) $display("FAIL boundary_release got=%0d exp=%0d", n, STABLE_CYCLES);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int width = 0;
    int n = 0;
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    while (pll_rst === 1'b1 && n < 50) begin n++; tick(); end
    repeat (4) tick();
    #3 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== RESET_VEC) $display("FAIL async_reset dut=%b exp=%b", dut_vec(), RESET_VEC);
    else n_pass++;
    repeat (2) tick();
    rst = 1'b0;
    while (pll_rst === 1'b1 && width < 50) begin width++; tick(); end
    n_checks++;
    if (width != RST_CYCLES) $display("FAIL restart_pulse got=%0d exp=%0d", width, RST_CYCLES);
    else n_pass++;
    n = 0;
    while (sys_rst === 1'b1 && n < 100) begin
      n++; tick();
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL model t=%0t dut=%b exp=%b", $time, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        locked = ($urandom_range(0, 3) != 0);
        hold   = $urandom_range(1, 40);
      end
      hold--;
      relock_req = ($urandom_range(0, 99) == 0);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL random_model t=%0t dut=%b exp=%b", $time, dut_vec(), model_vec());
      else n_pass++;
    end
    relock_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal_lock();
    test_lost_lock();
    test_lock_bounce();
    test_retries_to_fail();
    test_recovery();
    test_timeout_boundary();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
